xconf_dump: RTL and testbench
=============================

// Module: xconf_dump
// PURPOSE
// - Initiator-side counterpart of the configuration register write port: snapshots a flat
//   CONF_BITS configuration vector and replays it as a sequence of req/rnw/addr/data writes.
// - Used to save the active Versat configuration to host/config memory, or to copy it into
//   a second configuration register over the standard control interface.
// - Words are emitted MSB chunk first, matching the MSB-first field layout of the config vector.
// PARAMETERS
// - CONF_BITS   200   width of configuration vector to dump
// - DATA_W      32    write data width; chunk size
// - ADDR_W      10    control address width
// - BASE_ADDR   0     address of word 0; word k goes to BASE_ADDR+k
// - CLEAR_ADDR  1023  clear-command address (used only with CONF_DUMP_CLEAR_EN)
// - N_WORDS (localparam) = ceil(CONF_BITS/DATA_W); 7 with defaults
// PORTS
// - clk       in   1          clock
// - rst       in   1          reset, asynchronous, active-high
// - start     in   1          pulse: snapshot conf_in and begin dump
// - conf_in   in   CONF_BITS  live configuration vector
// - busy      out  1          high from cycle after accepted start until done
// - done      out  1          one-cycle pulse after last write acknowledged
// - req       out  1          write request
// - rnw       out  1          0 while req=1 (write); 1 when idle
// - addr      out  ADDR_W     write address, stable while req=1
// - data_out  out  DATA_W     write data, stable while req=1
// - ack       in   1          responder accepts current write in any cycle where req&ack
// BEHAVIOUR
// - Reset: state IDLE, busy=0, done=0, req=0, rnw=1, addr=0, data_out=0, word counter=0, snapshot=0.
// - FSM: IDLE -> (CLR) -> SEND -> FIN -> IDLE.
// - IDLE: start=1 latches conf_in into snapshot, counter=0; next state CLR if enabled else SEND.
// - Latency: start sampled at edge N -> req=1 with first addr/data valid after edge N (cycle N+1).
// - SEND: req=1, rnw=0, addr=BASE_ADDR+k, data_out=chunk k. On req&ack: if k==N_WORDS-1 go FIN,
//   else k<=k+1 and next word presented the following cycle (req stays high; back-to-back allowed).
// - Without ack, req/addr/data_out hold indefinitely; no timeout.
// - Chunk k = snapshot[CONF_BITS-1-k*DATA_W -: DATA_W]; last chunk if partial is left-aligned,
//   low bits zero (200/32: word 6 = {conf[7:0],24'h0}).
// - FIN: req=0, rnw=1, done=1 for exactly one cycle, busy=0 next cycle; return IDLE.
// - busy=1 in CLR/SEND; start while busy or in FIN is ignored (snapshot not modified).
// - conf_in changes after snapshot do not affect dumped data.
// - addr arithmetic modulo 2^ADDR_W (BASE_ADDR+k wraps silently).
// - rst mid-dump: immediate return to reset values; no done pulse; partial dump abandoned.
// CONFIGURATION
// - CONF_DUMP_CLEAR_EN defined: CLR state first issues one write addr=CLEAR_ADDR, data_out=0,
//   held until ack; then SEND from word 0. Total writes = N_WORDS+1.
// - Not defined: no CLR state; exactly N_WORDS writes; CLEAR_ADDR unused.
// TESTING
// - Reset: assert rst mid-cycle -> all outputs at reset values asynchronously, rnw=1.
// - conf_in=200'h...ABCD_1234 pattern, start, ack tied 1 -> 7 writes on 7 consecutive cycles,
//   addr 0..6, word0=conf[199:168], word6={conf[7:0],24'h0}; done pulse next cycle.
// - ack delayed 3 cycles on word 2 -> addr=2/data held 3 cycles, no skipped/duplicated words.
// - Change conf_in and pulse start during dump -> dumped data equals original snapshot; start ignored.
// - rst asserted after word 3 acked -> req=0, no done; new start dumps from word 0.
// - CONF_DUMP_CLEAR_EN, BASE_ADDR=16 -> first write addr=1023 data 0, then addr 16..22; 8 writes total.

Source files
------------

// File: rtl/xconf_dump.sv
// Snapshots a flat configuration vector and replays it as MSB-first DATA_W-wide writes.
// Optional feature: define CONF_DUMP_CLEAR_EN to issue a clear-command write before the dump.
module xconf_dump #(
    parameter int CONF_BITS  = 200,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 0,
    parameter int CLEAR_ADDR = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CONF_BITS-1:0] conf_in,
    output logic                 busy,
    output logic                 done,
    output logic                 req,
    output logic                 rnw,
    output logic [ADDR_W-1:0]    addr,
    output logic [DATA_W-1:0]    data_out,
    input  logic                 ack
);

    localparam int N_WORDS = (CONF_BITS + DATA_W - 1) / DATA_W;
    localparam int TOTAL_W = N_WORDS * DATA_W;
    localparam int PAD_W   = TOTAL_W - CONF_BITS;
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   word_cnt;
    logic [TOTAL_W-1:0] snapshot;

    // The snapshot is stored left-aligned and shifted one chunk per accepted word,
    // so the current word is always the top DATA_W bits and a partial last chunk
    // comes out with zero low bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            snapshot <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                snapshot <= TOTAL_W'(conf_in) << PAD_W;
                word_cnt <= '0;
            end else if (state == SEND && ack && word_cnt != LAST_WORD) begin
                snapshot <= snapshot << DATA_W;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        req        = 1'b0;
        rnw        = 1'b1;
        addr       = '0;
        data_out   = '0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef CONF_DUMP_CLEAR_EN
                    next_state = CLR;
`else
                    next_state = SEND;
`endif
                end
            end
`ifdef CONF_DUMP_CLEAR_EN
            CLR: begin
                busy = 1'b1;
                req  = 1'b1;
                rnw  = 1'b0;
                addr = ADDR_W'(CLEAR_ADDR);
                if (ack) begin
                    next_state = SEND;
                end
            end
`endif
            SEND: begin
                busy     = 1'b1;
                req      = 1'b1;
                rnw      = 1'b0;
                addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt);
                data_out = snapshot[TOTAL_W-1 -: DATA_W];
                if (ack && word_cnt == LAST_WORD) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xconf_dump.sv
// Directed bench for xconf_dump: full dumps, ack stalls, snapshot isolation and mid-dump reset.
// Expected words are hand-computed from the configuration patterns below.
module tb_xconf_dump;

    localparam int CONF_BITS = 200;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 10;
`ifdef CONF_DUMP_CLEAR_EN
    localparam int BASE = 16;
    localparam int NCLR = 1;
`else
    localparam int BASE = 0;
    localparam int NCLR = 0;
`endif
    localparam int NW = 7 + NCLR;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CONF_BITS-1:0] conf_in;
    logic                 busy;
    logic                 done;
    logic                 req;
    logic                 rnw;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_out;
    logic                 ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_words [7];
    logic [9:0]  exp_addr  [8];
    logic [31:0] exp_data  [8];

    localparam logic [199:0] PAT_A = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEF00D,
                                      32'h0BADC0DE, 32'hFEEDFACE, 8'hA5};
    localparam logic [199:0] PAT_C = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                      32'h55555555, 32'h66666666, 8'h77};

    xconf_dump #(
        .CONF_BITS (CONF_BITS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .CLEAR_ADDR(1023)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .conf_in (conf_in),
        .busy    (busy),
        .done    (done),
        .req     (req),
        .rnw     (rnw),
        .addr    (addr),
        .data_out(data_out),
        .ack     (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic setWordsA();
        exp_words[0] = 32'h01234567;
        exp_words[1] = 32'h89ABCDEF;
        exp_words[2] = 32'hDEADBEEF;
        exp_words[3] = 32'hCAFEF00D;
        exp_words[4] = 32'h0BADC0DE;
        exp_words[5] = 32'hFEEDFACE;
        exp_words[6] = 32'hA5000000;
    endtask

    task automatic setWordsC();
        exp_words[0] = 32'h11111111;
        exp_words[1] = 32'h22222222;
        exp_words[2] = 32'h33333333;
        exp_words[3] = 32'h44444444;
        exp_words[4] = 32'h55555555;
        exp_words[5] = 32'h66666666;
        exp_words[6] = 32'h77000000;
    endtask

    task automatic buildExpected();
        if (NCLR == 1) begin
            exp_addr[0] = 10'd1023;
            exp_data[0] = 32'h0;
        end
        for (int k = 0; k < 7; k++) begin
            exp_addr[k+NCLR] = 10'(BASE + k);
            exp_data[k+NCLR] = exp_words[k];
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " req"},  64'(req),      64'd0);
        checkOutput({tag, " rnw"},  64'(rnw),      64'd1);
        checkOutput({tag, " addr"}, 64'(addr),     64'd0);
        checkOutput({tag, " data"}, 64'(data_out), 64'd0);
        checkOutput({tag, " busy"}, 64'(busy),     64'd0);
        checkOutput({tag, " done"}, 64'(done),     64'd0);
    endtask

    task automatic applyStimulus(input logic [199:0] c);
        conf_in = c;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Walks the write sequence; stall_word gets stall_n ack-less cycles, disturb_word
    // changes conf_in and re-pulses start, stop_at abandons the dump before that write.
    task automatic runDump(input int stall_word, input int stall_n, input int disturb_word,
                           input int stop_at);
        int hold;
        for (int i = 0; i < NW; i++) begin
            if (i == stop_at) return;
            hold = (i == stall_word) ? stall_n : 0;
            for (int s = 0; s <= hold; s++) begin
                checkOutput($sformatf("req w%0d c%0d", i, s),  64'(req),      64'd1);
                checkOutput($sformatf("rnw w%0d c%0d", i, s),  64'(rnw),      64'd0);
                checkOutput($sformatf("busy w%0d c%0d", i, s), 64'(busy),     64'd1);
                checkOutput($sformatf("addr w%0d c%0d", i, s), 64'(addr),     64'(exp_addr[i]));
                checkOutput($sformatf("data w%0d c%0d", i, s), 64'(data_out), 64'(exp_data[i]));
                if (i == disturb_word && s == 0) begin
                    conf_in = ~conf_in;
                    start   = 1'b1;
                end else begin
                    start   = 1'b0;
                end
                ack = (s == hold);
                @(posedge clk);
                #1;
            end
        end
        ack   = 1'b0;
        start = 1'b0;
        checkOutput("fin done", 64'(done), 64'd1);
        checkOutput("fin req",  64'(req),  64'd0);
        checkOutput("fin rnw",  64'(rnw),  64'd1);
        checkOutput("fin busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        checkIdle("post");
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        ack     = 1'b0;
        conf_in = PAT_A;
        #3;
        checkIdle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkIdle("idle");

        // Back-to-back dump with ack tied high
        setWordsA();
        buildExpected();
        applyStimulus(PAT_A);
        runDump(-1, 0, -1, -1);

        // Three ack-less cycles on word 2
        applyStimulus(PAT_A);
        runDump(2 + NCLR, 3, -1, -1);

        // conf_in change and stray start mid-dump must not disturb the snapshot
        setWordsC();
        buildExpected();
        applyStimulus(PAT_C);
        runDump(-1, 0, 2 + NCLR, -1);

        // Reset after word 3 is acked, between clock edges
        setWordsA();
        buildExpected();
        applyStimulus(PAT_A);
        runDump(-1, 0, -1, 4 + NCLR);
        ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkIdle("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("after rst done", 64'(done), 64'd0);
            checkOutput("after rst req",  64'(req),  64'd0);
        end

        // Fresh dump restarts at word 0
        setWordsC();
        buildExpected();
        applyStimulus(PAT_C);
        runDump(-1, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
